spi_master_param: RTL and testbench

Parametrised full-duplex SPI master, successor to the fixed 8-bit write/read SPI controller used to drive the 25AA010A-class EEPROM. Adds configurable frame width, SCK divider, run-time CPOL/CPHA, multiple chip selects, and multi-frame transactions with CSN held low between frames. It sits between a host command sequencer and the SPI pins. One frame shifts DATA_W bits out on spi_do while capturing DATA_W bits from spi_di.

---
 rtl/spi_master_param.sv | 196 +++++++++++++++++++
 tb/tb_spi_master_param.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// spi_master_param: full-duplex SPI master with configurable frame width,
// SCK divider, run-time CPOL/CPHA, multiple selects and CSN held across frames.
module spi_master_param #(
    parameter  int DATA_W  = 8,
    parameter  int CLK_DIV = 25,
    parameter  int NUM_CS  = 1,
    localparam int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk_50M,
    input  logic              reset_n,
    input  logic              start,
    input  logic              end_xfer,
    input  logic              hold_cs,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              done,
    output logic              busy,
    output logic [NUM_CS-1:0] spi_csn,
    output logic              spi_sck,
    output logic              spi_do,
    input  logic              spi_di
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HALF_W = $clog2(2 * DATA_W);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD_T,
        S_HELD,
        S_GAP
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic [HALF_W-1:0]   r_half;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic [DATA_W-1:0]   r_rxd;
    logic                r_cpha;
    logic                r_hold;
    logic                r_no_done;
    logic [NUM_CS-1:0]   r_csn;
    logic                r_sck;
    logic                r_do;
    logic                r_busy;
    logic                r_done;

    logic                w_tick;
    logic                w_lead;
    logic                w_last;
    logic                w_sample;
    logic [DIV_W-1:0]    w_div_nxt;

    assign w_tick    = (r_div == DIV_LAST);
    assign w_lead    = ~r_half[0];
    assign w_last    = (r_half == HALF_LAST);
    // cpha=0 samples on leading edges, cpha=1 on trailing edges
    assign w_sample  = (w_lead != r_cpha);
    assign w_div_nxt = w_tick ? '0 : r_div + DIV_W'(1);

    function automatic logic [NUM_CS-1:0] f_csn(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (sel == CS_W'(i)) begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_half    <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rxd     <= '0;
            r_cpha    <= 1'b0;
            r_hold    <= 1'b0;
            r_no_done <= 1'b0;
            r_csn     <= '1;
            r_sck     <= 1'b0;
            r_do      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_SETUP;
                        r_div     <= '0;
                        r_tx      <= tx_data;
                        r_hold    <= hold_cs;
                        r_cpha    <= cpha;
                        r_no_done <= 1'b0;
                        r_busy    <= 1'b1;
                        r_csn     <= f_csn(cs_sel);
                        r_sck     <= cpol;
                        r_do      <= cpha ? 1'b0 : tx_data[DATA_W-1];
                    end
                end
                S_SETUP: begin
                    r_div <= w_div_nxt;
                    if (w_tick) begin
                        r_state <= S_SHIFT;
                        r_half  <= '0;
                    end
                end
                S_SHIFT: begin
                    r_div <= w_div_nxt;
                    if (w_tick) begin
                        r_sck  <= ~r_sck;
                        r_half <= r_half + HALF_W'(1);
                        if (w_sample) begin
                            r_rx <= {r_rx[DATA_W-2:0], spi_di};
                        end else begin
                            r_do <= r_cpha ? r_tx[DATA_W-1] : r_tx[DATA_W-2];
                            r_tx <= r_tx << 1;
                        end
                        if (w_last) begin
                            r_state <= S_HOLD_T;
                        end
                    end
                end
                S_HOLD_T: begin
                    r_div <= w_div_nxt;
                    if (w_tick) begin
                        if (r_hold) begin
                            r_state <= S_HELD;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_rxd   <= r_rx;
                        end else begin
                            r_state   <= S_GAP;
                            r_csn     <= '1;
                            r_no_done <= 1'b0;
                        end
                    end
                end
                S_HELD: begin
                    // a simultaneous end_xfer loses to start
                    if (start) begin
                        r_state <= S_SHIFT;
                        r_div   <= '0;
                        r_half  <= '0;
                        r_tx    <= tx_data;
                        r_hold  <= hold_cs;
                        r_busy  <= 1'b1;
                        r_do    <= r_cpha ? 1'b0 : tx_data[DATA_W-1];
                    end else if (end_xfer) begin
                        r_state   <= S_GAP;
                        r_div     <= '0;
                        r_csn     <= '1;
                        r_no_done <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_GAP: begin
                    r_div <= w_div_nxt;
                    if (w_tick) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_do    <= 1'b0;
                        if (!r_no_done) begin
                            r_done <= 1'b1;
                            r_rxd  <= r_rx;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_data = r_rxd;
    assign done    = r_done;
    assign busy    = r_busy;
    assign spi_csn = r_csn;
    assign spi_sck = r_sck;
    assign spi_do  = r_do;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: protocol-level SPI slave on a default instance
// and a 16-bit loopback instance, randomized frames against a reference model.
module tb_spi_master_param;

    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic       a_start = 0, a_end = 0, a_hold = 0, a_cpol = 0, a_cpha = 0;
    logic [0:0] a_cs = '0;
    logic [7:0] a_tx = '0;
    logic [7:0] a_rx;
    logic       a_done, a_busy, a_sck, a_do, a_di;
    logic [0:0] a_csn;

    logic        b_start = 0, b_end = 0, b_hold = 0, b_cpol = 1, b_cpha = 1;
    logic [1:0]  b_cs = '0;
    logic [15:0] b_tx = '0;
    logic [15:0] b_rx;
    logic        b_done, b_busy, b_sck, b_do, b_di;
    logic [2:0]  b_csn;

    spi_master_param u_a (
        .clk_50M(clk), .reset_n(rst_n), .start(a_start), .end_xfer(a_end),
        .hold_cs(a_hold), .cpol(a_cpol), .cpha(a_cpha), .cs_sel(a_cs),
        .tx_data(a_tx), .rx_data(a_rx), .done(a_done), .busy(a_busy),
        .spi_csn(a_csn), .spi_sck(a_sck), .spi_do(a_do), .spi_di(a_di)
    );

    spi_master_param #(.DATA_W(16), .CLK_DIV(1), .NUM_CS(3)) u_b (
        .clk_50M(clk), .reset_n(rst_n), .start(b_start), .end_xfer(b_end),
        .hold_cs(b_hold), .cpol(b_cpol), .cpha(b_cpha), .cs_sel(b_cs),
        .tx_data(b_tx), .rx_data(b_rx), .done(b_done), .busy(b_busy),
        .spi_csn(b_csn), .spi_sck(b_sck), .spi_do(b_do), .spi_di(b_di)
    );

    assign b_di = b_do;

    // SPI slave: shifts miso_w out MSB first, records MOSI per mode
    logic       m_cpol = 0, m_cpha = 0;
    logic [7:0] miso_w = '0, s_rx = '0, mosi_last = '0;
    int         ns = 0, n_lead = 0, n_csfall = 0;
    bit         lead_seen = 0;

    assign a_di = (a_csn[0] == 1'b0 && ns < 8) ? miso_w[3'(7 - ns)] : 1'b0;

    task automatic take();
        s_rx = {s_rx[6:0], a_do};
        ns++;
        if (ns == 8) begin
            mosi_last = s_rx;
            ns = 0;
        end
    endtask

    task automatic sck_edge(input bit lead);
        if (a_csn[0] !== 1'b0) return;
        if (lead) begin
            lead_seen = 1;
            n_lead++;
            if (!m_cpha) take();
        end else if (lead_seen) begin
            lead_seen = 0;
            if (m_cpha) take();
        end
    endtask

    always @(posedge a_sck) sck_edge(m_cpol == 1'b0);
    always @(negedge a_sck) sck_edge(m_cpol == 1'b1);
    always @(negedge a_csn[0]) n_csfall++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // done cycle counted from the start-sampling edge, default parameters
    function automatic int lat_of(input bit from_idle, input bit hold);
        if (from_idle) return hold ? 1 + 18 * 25 : 1 + 19 * 25;
        return hold ? 1 + 17 * 25 : 1 + 18 * 25;
    endfunction

    task automatic rnd_mode();
        m_cpol = 1'($urandom);
        m_cpha = 1'($urandom);
        a_cpol = m_cpol;
        a_cpha = m_cpha;
    endtask

    task automatic a_frame(input string tag, input logic [7:0] tx,
                           input bit hold, input bit from_idle,
                           input bit with_end, input bit spam,
                           input bit valid);
        int k;
        logic pb;
        logic [7:0] exp_rx;
        exp_rx = valid ? miso_w : 8'h00;
        if (from_idle) begin
            ns = 0;
            lead_seen = 0;
            s_rx = '0;
        end
        n_lead = 0;
        a_tx = tx;
        a_hold = hold;
        a_end = with_end;
        a_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        k = 1;
        pb = a_busy;
        a_end = 1'b0;
        if (!spam) a_start = 1'b0;
        while (a_done !== 1'b1 && k < 1000) begin
            if (spam) a_tx = 8'($urandom);
            pb = a_busy;
            @(negedge clk);
            k++;
        end
        a_start = 1'b0;
        chk({tag, " latency"}, k, lat_of(from_idle, hold));
        chk({tag, " busy before done"}, pb, 1);
        chk({tag, " busy at done"}, a_busy, 0);
        chk({tag, " rx_data"}, a_rx, exp_rx);
        if (valid) begin
            chk({tag, " mosi"}, mosi_last, tx);
            chk({tag, " sck edges"}, n_lead, 8);
        end
        chk({tag, " sck idle"}, a_sck, m_cpol);
        @(negedge clk);
        chk({tag, " done width"}, a_done, 0);
        chk({tag, " rx stable"}, a_rx, exp_rx);
    endtask

    initial begin
        int k;
        int nd;
        logic [2:0] exp_csn;
        rst_n = 1'b1;
        #5 rst_n = 1'b0;
        #1;
        chk("rst a csn", a_csn, 1);
        chk("rst a sck", a_sck, 0);
        chk("rst a do", a_do, 0);
        chk("rst a busy", a_busy, 0);
        chk("rst a done", a_done, 0);
        chk("rst a rx", a_rx, 0);
        chk("rst b csn", b_csn, 3'b111);
        chk("rst b rx", b_rx, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // mode 0 write-enable style frame
        m_cpol = 0; m_cpha = 0; a_cpol = 0; a_cpha = 0; a_cs = '0;
        miso_w = 8'($urandom);
        n_csfall = 0;
        a_frame("wren", 8'h06, 0, 1, 0, 0, 1);
        chk("wren csn pulses", n_csfall, 1);

        // three frames in one CSN window; select/mode inputs scrambled
        rnd_mode();
        n_csfall = 0;
        miso_w = 8'($urandom);
        a_frame("mf0", 8'h02, 1, 1, 0, 0, 1);
        a_cpol = ~m_cpol; a_cpha = ~m_cpha; a_cs = 1'b1;
        miso_w = 8'($urandom);
        a_frame("mf1", 8'h00, 1, 0, 1, 0, 1);
        miso_w = 8'h78;
        a_frame("mf2", 8'h78, 0, 0, 0, 0, 1);
        chk("mf csn pulses", n_csfall, 1);
        a_cs = '0;

        // start held high through a frame, then end_xfer from HELD
        rnd_mode();
        miso_w = 8'($urandom);
        a_frame("spam", 8'($urandom), 1, 1, 0, 1, 1);
        a_end = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_end = 1'b0;
        chk("endx csn", a_csn, 1);
        chk("endx busy", a_busy, 1);
        nd = 0;
        for (int i = 2; i <= 75; i++) begin
            @(negedge clk);
            if (a_done === 1'b1) nd++;
            if (i == 25) chk("endx busy gap", a_busy, 1);
            if (i == 26) chk("endx busy idle", a_busy, 0);
        end
        chk("endx no done", nd, 0);

        // out-of-range select: no CSN, frame still completes
        rnd_mode();
        a_cs = 1'b1;
        n_csfall = 0;
        miso_w = 8'($urandom);
        a_frame("badcs", 8'($urandom), 0, 1, 0, 0, 0);
        chk("badcs csn pulses", n_csfall, 0);
        a_cs = '0;

        for (int r = 0; r < 5; r++) begin
            rnd_mode();
            miso_w = 8'($urandom) | 8'h80;
            a_frame($sformatf("rnd%0d", r), 8'($urandom), 0, 1, 0, 0, 1);
        end

        // asynchronous reset in the middle of SHIFT
        rnd_mode();
        miso_w = 8'($urandom);
        a_tx = 8'($urandom);
        a_hold = 1'b0;
        a_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_start = 1'b0;
        repeat (200) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst csn", a_csn, 1);
        chk("midrst sck", a_sck, 0);
        chk("midrst busy", a_busy, 0);
        chk("midrst done", a_done, 0);
        chk("midrst do", a_do, 0);
        chk("midrst rx", a_rx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rnd_mode();
        miso_w = 8'($urandom);
        a_frame("postrst", 8'($urandom), 0, 1, 0, 0, 1);

        // 16-bit, divider 1, mode 3 loopback
        for (int r = 0; r < 3; r++) begin
            b_cs = (r == 2) ? 2'd3 : 2'($urandom_range(0, 2));
            b_tx = (r == 0) ? 16'hA55A : 16'($urandom);
            exp_csn = 3'b111;
            if (b_cs < 2'd3) exp_csn[b_cs] = 1'b0;
            b_start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            b_start = 1'b0;
            k = 1;
            chk($sformatf("b%0d csn", r), b_csn, exp_csn);
            while (b_done !== 1'b1 && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("b%0d latency", r), k, 36);
            chk($sformatf("b%0d rx", r), b_rx, b_tx);
            chk($sformatf("b%0d sck idle", r), b_sck, 1);
            chk($sformatf("b%0d busy", r), b_busy, 0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
